// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions.
//   estado_t    : fetch FSM states (FETCH, WAIT, VALID, HALT)
//   NOP         : addi x0,x0,0, the instruction register value after reset
//   OP_*        : base opcodes used by the decode slices downstream
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } estado_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/contador_programa.sv
// Program counter register with next-PC selection and target alignment check.
//   clk, rst_n   : clock, async active-low reset (pc <= RESET_PC)
//   advance      : current instruction retires this cycle
//   redirect     : branch_taken | jump for the retiring instruction
//   target_addr  : redirect destination
//   pc           : address of the held instruction
//   pc_plus4     : pc + 4, wrapping modulo 2^32
//   misaligned   : retiring redirect points to a non word-aligned target
module contador_programa #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  assign pc_plus4   = pc + 32'd4;
  assign misaligned = advance && redirect && (target_addr[1:0] != 2'b00);

  // A misaligned redirect leaves pc pointing at the faulting instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (advance && !misaligned) begin
      pc <= redirect ? target_addr : pc_plus4;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: one outstanding request, no prefetch.
//   clk, rst_n                    : clock, async active-low reset
//   imem_req/imem_addr            : fetch request and word-aligned address
//   imem_ready                    : memory accepts the request
//   imem_rvalid/imem_rdata        : returned instruction word
//   stall                         : downstream holds the current instruction
//   branch_taken, jump, target_addr : redirect controls for the retiring instruction
//   instr_valid, instr, pc, pc_plus4 : held instruction and its address
//   opcode, funct3, funct7        : decode slices of instr
//   fault                         : sticky misaligned-target or memory timeout
module busca_instrucao
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam int                CNT_W    = $clog2(IMEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  estado_t          state;
  logic             started;
  logic [CNT_W-1:0] wait_cnt;
  logic             advance;
  logic             redirect;
  logic             misaligned;

  assign redirect = branch_taken | jump;
  assign advance  = (state == VALID) && !stall;

  contador_programa #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    .redirect    (redirect),
    .target_addr (target_addr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misaligned  (misaligned)
  );

  // 'started' keeps the request low until the first clock edge after reset
  // release, so a request never appears asynchronously with rst_n.
  assign imem_req    = (state == FETCH) && started;
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      started  <= 1'b0;
      instr    <= NOP;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      started <= 1'b1;
      unique case (state)
        FETCH: begin
          if (started && imem_ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          // Data arriving on the final allowed cycle still wins over timeout.
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= VALID;
          end else if (wait_cnt == CNT_LAST) begin
            fault <= 1'b1;
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        VALID: begin
          if (!stall) begin
            if (misaligned) begin
              fault <= 1'b1;
              state <= HALT;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;
  localparam logic [31:0] NOPW   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] target_addr = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Transaction-level reference: address of the held instruction, its word,
  // and whether the stage has faulted.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  bit          exp_fault;

  logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                          7'b0100011, 7'b1100011, 7'b1101111};

  busca_instrucao #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .jump(jump),
    .target_addr(target_addr),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4),
    .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 5)];
    return w;
  endfunction

  function automatic void model_reset();
    exp_pc    = RST_PC;
    exp_instr = NOPW;
    exp_fault = 1'b0;
  endfunction

  function automatic void model_retire(bit br, bit jp, logic [31:0] tgt);
    if (br || jp) begin
      if (tgt % 4 != 0) exp_fault = 1'b1;
      else exp_pc = tgt;
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    imem_ready = 0; imem_rvalid = 0; stall = 0; branch_taken = 0; jump = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  // Drives one complete memory transaction: waits for the request, holds
  // ready low for rdly cycles (optionally with stray rvalid pulses), then
  // accepts and returns data after vdly empty WAIT cycles.
  task automatic do_fetch(input int rdly, input int vdly, input bit junk,
                          input logic [31:0] data,
                          output logic [31:0] addr_seen, output bit stable,
                          output bit ok);
    int guard;
    guard = 0; ok = 1; stable = 1; addr_seen = '0;
    while (imem_req !== 1'b1 && guard < 20) begin step(); guard++; end
    if (imem_req !== 1'b1) begin ok = 0; return; end
    addr_seen = imem_addr;
    repeat (rdly) begin
      imem_rvalid = junk; imem_rdata = $urandom;
      step();
      if (imem_req !== 1'b1 || imem_addr !== addr_seen) stable = 0;
    end
    imem_rvalid = 0;
    imem_ready = 1; step(); imem_ready = 0;
    repeat (vdly) step();
    imem_rvalid = 1; imem_rdata = data; step();
    imem_rvalid = 0; imem_rdata = $urandom;
    exp_instr = data;
  endtask

  task automatic retire(input bit br, input bit jp, input logic [31:0] tgt);
    stall = 0; branch_taken = br; jump = jp; target_addr = tgt;
    step();
    branch_taken = 0; jump = 0;
    model_retire(br, jp, tgt);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b expected 0", fault); end
    n_cmp++; if (pc !== RST_PC) begin n_err++; $display("FAIL rst_pc: got %h expected %h", pc, RST_PC); end
    n_cmp++; if (instr !== NOPW) begin n_err++; $display("FAIL rst_instr: got %h expected %h", instr, NOPW); end
    n_cmp++; if (pc_plus4 !== RST_PC + 32'd4) begin n_err++; $display("FAIL rst_pc4: got %h expected %h", pc_plus4, RST_PC + 32'd4); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL req_before_edge: got %b expected 0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL req_first_edge: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL first_addr: got %h expected %h", imem_addr, RST_PC); end
  endtask

  task automatic test_sequential();
    int t [3];
    logic [31:0] d, a;
    bit st, ok;
    for (int i = 0; i < 3; i++) begin
      d = rand_word();
      do_fetch(0, 0, 0, d, a, st, ok);
      t[i] = cyc;
      n_cmp++; if (!ok || a !== 32'(i * 4)) begin n_err++; $display("FAIL seq_addr%0d: got %h expected %h", i, a, 32'(i * 4)); end
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid%0d: got %b expected 1", i, instr_valid); end
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, exp_pc); end
      n_cmp++; if (opcode !== d[6:0]) begin n_err++; $display("FAIL seq_op%0d: got %h expected %h", i, opcode, d[6:0]); end
      retire(0, 0, 32'h0);
      n_cmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_rereq%0d: got req %b valid %b expected 1 0", i, imem_req, instr_valid); end
    end
    n_cmp++; if (t[1] - t[0] != 3) begin n_err++; $display("FAIL seq_period01: got %0d expected 3", t[1] - t[0]); end
    n_cmp++; if (t[2] - t[1] != 3) begin n_err++; $display("FAIL seq_period12: got %0d expected 3", t[2] - t[1]); end
  endtask

  task automatic test_stall();
    logic [31:0] d, a;
    bit st, ok;
    d = rand_word();
    do_fetch(1, 2, 0, d, a, st, ok);
    stall = 1; branch_taken = 1; target_addr = 32'h0000_0400;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== d || pc !== exp_pc) begin n_err++; $display("FAIL stall_hold%0d: got v%b %h @%h expected v1 %h @%h", i, instr_valid, instr, pc, d, exp_pc); end
    end
    branch_taken = 0;
    retire(0, 0, 32'h0);
    stall = 0;
    n_cmp++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin n_err++; $display("FAIL stall_next: got %h req %b expected %h req 1", imem_addr, imem_req, exp_pc); end
  endtask

  task automatic test_random();
    logic [31:0] d, a, tgt;
    bit st, ok, br, jp;
    int r;
    for (int i = 0; i < 25; i++) begin
      d = rand_word();
      do_fetch($urandom_range(0, 3), $urandom_range(0, TMO - 1), bit'($urandom_range(0, 1)), d, a, st, ok);
      n_cmp++; if (!ok || a !== exp_pc || !st) begin n_err++; $display("FAIL rnd_addr%0d: got %h stable %b expected %h", i, a, st, exp_pc); end
      n_cmp++; if (instr_valid !== 1'b1 || instr !== exp_instr || pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
        n_err++; $display("FAIL rnd_hold%0d: got v%b %h @%h+4=%h expected %h @%h", i, instr_valid, instr, pc, pc_plus4, exp_instr, exp_pc); end
      n_cmp++; if (opcode !== exp_instr[6:0] || funct3 !== exp_instr[14:12] || funct7 !== exp_instr[31:25]) begin
        n_err++; $display("FAIL rnd_fields%0d: got %h/%h/%h for %h", i, opcode, funct3, funct7, exp_instr); end
      r = $urandom_range(0, 2);
      stall = 1;
      for (int k = 0; k < r; k++) begin
        branch_taken = bit'($urandom_range(0, 1)); jump = bit'($urandom_range(0, 1)); target_addr = $urandom;
        step();
      end
      n_cmp++; if (instr_valid !== 1'b1 || instr !== exp_instr || pc !== exp_pc) begin n_err++; $display("FAIL rnd_stall%0d: got %h @%h expected %h @%h", i, instr, pc, exp_instr, exp_pc); end
      r = $urandom_range(0, 4);
      br = (r == 2 || r == 4); jp = (r == 3 || r == 4);
      tgt = $urandom & 32'hFFFF_FFFC;
      retire(br, jp, tgt);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || fault !== 1'b0) begin n_err++; $display("FAIL rnd_next%0d: got %h req %b fault %b expected %h", i, imem_addr, imem_req, fault, exp_pc); end
    end
  endtask

  task automatic test_jump();
    logic [31:0] d, a;
    bit st, ok;
    apply_reset();
    do_fetch(0, 0, 0, rand_word(), a, st, ok);
    retire(0, 1, 32'h0000_0100);
    n_cmp++; if (imem_addr !== 32'h0000_0100 || imem_req !== 1'b1) begin n_err++; $display("FAIL jump_addr: got %h req %b expected 00000100", imem_addr, imem_req); end
    d = rand_word();
    do_fetch(0, 1, 0, d, a, st, ok);
    n_cmp++; if (pc !== 32'h0000_0100 || instr !== d) begin n_err++; $display("FAIL jump_fetch: got %h @%h expected %h @00000100", instr, pc, d); end
    retire(1, 1, 32'h0000_0102);
    repeat (3) step();
    n_cmp++; if (fault !== exp_fault || fault !== 1'b1) begin n_err++; $display("FAIL misalign_fault: got %b expected 1", fault); end
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL misalign_halt: got req %b valid %b expected 0 0", imem_req, instr_valid); end
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL misalign_pc: got %h expected %h", pc, exp_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit st, ok;
    apply_reset();
    do_fetch(0, 0, 0, rand_word(), a, st, ok);
    retire(0, 1, 32'hFFFF_FFFC);
    do_fetch(0, 0, 0, rand_word(), a, st, ok);
    n_cmp++; if (a !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc4: got addr %h pc4 %h expected fffffffc 00000000", a, pc_plus4); end
    retire(0, 0, 32'h0);
    n_cmp++; if (imem_addr !== exp_pc || imem_req !== 1'b1 || fault !== 1'b0) begin n_err++; $display("FAIL wrap_next: got %h req %b fault %b expected %h 1 0", imem_addr, imem_req, fault, exp_pc); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    apply_reset();
    imem_ready = 1; step(); imem_ready = 0;
    repeat (TMO - 1) step();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b expected 0", fault); end
    step();
    n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL tmo_fault: got %b expected 1", fault); end
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL tmo_halt: got req %b valid %b expected 0 0", imem_req, instr_valid); end
    d = rand_word();
    imem_rvalid = 1; imem_rdata = d; step(); imem_rvalid = 0;
    repeat (3) step();
    n_cmp++; if (instr !== exp_instr || instr_valid !== 1'b0 || imem_req !== 1'b0 || fault !== 1'b1) begin
      n_err++; $display("FAIL tmo_late_rvalid: got %h v%b req %b fault %b expected %h v0 req 0 fault 1", instr, instr_valid, imem_req, fault, exp_instr); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a;
    bit st, ok;
    apply_reset();
    do_fetch(0, 0, 0, rand_word(), a, st, ok);
    retire(0, 1, 32'h0000_0200);
    imem_ready = 1; step(); imem_ready = 0; step();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (imem_req !== 1'b0 || pc !== RST_PC || instr !== NOPW || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_state: got req %b pc %h instr %h v%b expected 0 %h %h 0", imem_req, pc, instr, instr_valid, RST_PC, NOPW); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    imem_rvalid = 1; imem_rdata = rand_word(); step(); imem_rvalid = 0;
    n_cmp++; if (instr !== NOPW || instr_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ignore: got %h v%b expected %h v0", instr, instr_valid, NOPW); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_err++; $display("FAIL midrst_req: got req %b %h expected 1 %h", imem_req, imem_addr, RST_PC); end
    do_fetch(0, 0, 0, rand_word(), a, st, ok);
    n_cmp++; if (!ok || a !== RST_PC || instr !== exp_instr) begin n_err++; $display("FAIL midrst_fetch: got %h %h expected %h %h", a, instr, RST_PC, exp_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_random();
    test_jump();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have parameter IMEM_TIMEOUT, default 16, giving the maximum WAIT cycles before a fetch fault.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  async active-low reset
  imem_req  out  1  fetch request valid
  imem_addr  out  32  word-aligned fetch address
  imem_ready  in  1  memory accepts request this cycle
  imem_rvalid  in  1  read data valid
  imem_rdata  in  32  instruction word
  stall  in  1  downstream holds current instruction
  branch_taken  in  1  resolved conditional branch taken
  jump  in  1  unconditional jump (JAL)
  target_addr  in  32  branch/jump target
  instr_valid  out  1  instr/pc outputs hold a live instruction
  instr  out  32  held instruction word
  opcode  out  7  instr[6:0]
  funct3  out  3  instr[14:12]
  funct7  out  7  instr[31:25]
  pc  out  32  address of held instruction
  pc_plus4  out  32  pc + 4
  fault  out  1  sticky fetch fault (misaligned target or timeout)

Function
REQ-004 The FSM SHALL have the states FETCH, WAIT, VALID and HALT.
REQ-005 In FETCH, imem_req=1 and imem_addr=pc; on imem_ready=1 the FSM SHALL go to WAIT; otherwise imem_addr SHALL stay stable.
REQ-006 In WAIT, on imem_rvalid=1, instr SHALL capture imem_rdata and the FSM SHALL go to VALID next cycle.
REQ-007 imem_rvalid outside WAIT SHALL be ignored (no capture, no state change).
REQ-008 instr_valid SHALL be 1 only in VALID; opcode/funct3/funct7 SHALL be combinational slices of instr.
REQ-009 In VALID with stall=1, instr, pc and instr_valid SHALL hold unchanged; branch_taken and jump SHALL be ignored.
REQ-010 In VALID with stall=0, pc SHALL update to target_addr if (branch_taken|jump), else to pc_plus4, and the FSM SHALL go to FETCH.
REQ-011 branch_taken and jump asserted together SHALL behave as a single redirect to target_addr.
REQ-012 pc_plus4 SHALL be (pc+4) mod 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no fault.
REQ-013 A redirect with target_addr[1:0]!=0 SHALL leave pc unchanged, set fault, and enter HALT.
REQ-014 The WAIT-cycle counter SHALL reset on WAIT entry; reaching IMEM_TIMEOUT cycles without rvalid SHALL set fault and enter HALT.
REQ-015 HALT SHALL be exited only by reset, with imem_req=0 and instr_valid=0.
REQ-016 Zero-wait memory (ready=1, rvalid one cycle after acceptance) SHALL give req at cycle 0, rvalid at 1, instr_valid at 2, next req at 3: a 3-cycle fetch period.
REQ-017 At most one request SHALL be outstanding; no prefetch.

Reset
REQ-018 While rst_n=0: state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), fault=0, counter=0, instr_valid=0; imem_req SHALL be forced 0.
REQ-019 imem_req SHALL assert on the first rising edge after rst_n deasserts.
REQ-020 Reset mid-WAIT SHALL abandon the request; any late rvalid SHALL be ignored (REQ-007).

Structure
REQ-021 FSM state encodings, NOP constant and opcode constants (7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111) SHALL live in shared package riscv_pkg.
REQ-022 The PC register with next-PC mux and alignment check SHALL be sub-module contador_programa; FSM, counter and instruction register stay in the top.

Verification
REQ-023 Zero-wait memory, stall=0: fetches at 0x0, 0x4, 0x8 -> instr_valid every 3 cycles with matching pc and opcode.
REQ-024 Stall=1 for 5 cycles in VALID with branch_taken=1 -> instr/pc unchanged; after release without redirect -> next fetch at pc+4.
REQ-025 jump=1, target_addr=0x100 -> next imem_addr=0x100; target_addr=0x102 -> fault=1, HALT, imem_req=0.
REQ-026 pc=0xFFFF_FFFC, no redirect -> next imem_addr=0x0000_0000, fault=0.
REQ-027 imem_rvalid withheld 16 cycles -> fault=1; rvalid arriving after HALT -> no capture.
REQ-028 rst_n pulsed low mid-WAIT, rvalid one cycle after release -> ignored; first req at RESET_PC.
